// File: rtl/prog_clk_div_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_clk_div_if
// Brief    : Control/status bundle of the programmable clock divider.
// Revision : 1.0 - initial release
// ============================================================================
interface prog_clk_div_if #(
    parameter int DIV_WID = 16
);
    logic               i_ce;
    logic [DIV_WID-1:0] i_div;
    logic               i_div_load;
    logic               o_clk;
    logic               o_rise_stb;
    logic               o_fall_stb;
    logic [DIV_WID-1:0] o_div;
    logic               o_pend;
    logic               o_err;

    modport master (
        output i_ce, i_div, i_div_load,
        input  o_clk, o_rise_stb, o_fall_stb, o_div, o_pend, o_err
    );

    modport slave (
        input  i_ce, i_div, i_div_load,
        output o_clk, o_rise_stb, o_fall_stb, o_div, o_pend, o_err
    );
endinterface
`default_nettype wire

// File: rtl/prog_clk_div.sv
`default_nettype none
// ============================================================================
// Module   : prog_clk_div
// Brief    : Runtime-programmable integer clock divider with edge strobes.
// Revision : 1.0 - initial release
// ============================================================================
module prog_clk_div #(
    parameter int DIV_WID     = 16,
    parameter int DEFAULT_DIV = 8
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    prog_clk_div_if.slave bus
);
    localparam logic [DIV_WID-1:0] c_DEFAULT_DIV = DIV_WID'(DEFAULT_DIV);
    localparam logic [1:0] c_ST_RESET = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_IDLE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [DIV_WID-1:0] r_cnt;
    logic [DIV_WID-1:0] r_div;
    logic [DIV_WID-1:0] r_pend_div;
    logic               r_pend;
    logic               r_clk;
    logic               r_rise;
    logic               r_fall;
    logic               r_err;

    logic               w_count;
    logic               w_apply;
    logic [DIV_WID-1:0] w_cnt_next;
    logic [DIV_WID-1:0] w_half;
    logic               w_last;
    logic               w_div_ok;
    logic               w_load_ok;
    logic               w_load_bad;

    assign w_half     = r_div >> 1;
    assign w_last     = (r_cnt == (r_div - DIV_WID'(1)));
    assign w_div_ok   = (bus.i_div >= DIV_WID'(2));
    assign w_load_ok  = bus.i_div_load & w_div_ok;
    assign w_load_bad = bus.i_div_load & ~w_div_ok;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= c_ST_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_RESET: w_state_next = bus.i_ce ? c_ST_RUN : c_ST_RESET;
            c_ST_RUN:   w_state_next = bus.i_ce ? c_ST_RUN : c_ST_IDLE;
            c_ST_IDLE:  w_state_next = bus.i_ce ? c_ST_RUN : c_ST_IDLE;
            default:    w_state_next = c_ST_RESET;
        endcase
    end

    // Counting happens only on edges that stay in RUN; the edge leaving
    // RESET/IDLE holds everything, and a new divisor lands only on a wrap
    // or while parked at the start of a period.
    always_comb begin
        w_count    = 1'b0;
        w_apply    = 1'b0;
        w_cnt_next = r_cnt;
        case (r_state)
            c_ST_RUN: begin
                if (bus.i_ce) begin
                    w_count    = 1'b1;
                    w_cnt_next = w_last ? '0 : r_cnt + DIV_WID'(1);
                    w_apply    = w_last & r_pend;
                end
            end
            c_ST_RESET: w_apply = r_pend;
            c_ST_IDLE:  w_apply = r_pend & (r_cnt == '0);
            default:    w_apply = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_cnt      <= '0;
            r_clk      <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_err      <= 1'b0;
            r_div      <= c_DEFAULT_DIV;
            r_pend_div <= '0;
            r_pend     <= 1'b0;
        end else begin
            r_err <= w_load_bad;
            if (w_count) begin
                r_cnt  <= w_cnt_next;
                r_clk  <= (w_cnt_next >= w_half);
                r_rise <= (w_cnt_next == w_half);
                r_fall <= (w_cnt_next == '0);
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end
            if (w_apply) begin
                r_div <= r_pend_div;
            end
            // A fresh load wins over clearing, so load+apply leaves it pending.
            if (w_load_ok) begin
                r_pend_div <= bus.i_div;
                r_pend     <= 1'b1;
            end else if (w_apply) begin
                r_pend     <= 1'b0;
            end
        end
    end

    assign bus.o_clk      = r_clk;
    assign bus.o_rise_stb = r_rise;
    assign bus.o_fall_stb = r_fall;
    assign bus.o_div      = r_div;
    assign bus.o_pend     = r_pend;
    assign bus.o_err      = r_err;
endmodule
`default_nettype wire

// File: tb/tb_prog_clk_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_clk_div
// Brief    : Directed self-checking bench for prog_clk_div.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_clk_div;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    prog_clk_div_if #(.DIV_WID(16)) bus();

    prog_clk_div #(.DIV_WID(16), .DEFAULT_DIV(8)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.i_ce = 1'b0;
        bus.i_div = '0;
        bus.i_div_load = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({bus.o_clk, bus.o_rise_stb, bus.o_fall_stb, bus.o_pend, bus.o_err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.o_clk, bus.o_rise_stb, bus.o_fall_stb, bus.o_pend, bus.o_err});
        end
        n_cmp++;
        if (bus.o_div !== 16'd8) begin
            n_bad++;
            $display("FAIL reset_div: got %0d expected 8", bus.o_div);
        end
    endtask

    task automatic test_default_run();
        logic [2:0] exp3;
        int c;
        bus.i_ce = 1'b1;
        tick();
        n_cmp++;
        if ({bus.o_clk, bus.o_rise_stb, bus.o_fall_stb} !== 3'b000) begin
            n_bad++;
            $display("FAIL leave_reset: got %b expected 000", {bus.o_clk, bus.o_rise_stb, bus.o_fall_stb});
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            c = k % 8;
            exp3 = {c >= 4, c == 4, c == 0};
            n_cmp++;
            if ({bus.o_clk, bus.o_rise_stb, bus.o_fall_stb} !== exp3 || bus.o_div !== 16'd8) begin
                n_bad++;
                $display("FAIL wave_n8 cyc %0d: got %b div %0d expected %b div 8",
                         k, {bus.o_clk, bus.o_rise_stb, bus.o_fall_stb}, bus.o_div, exp3);
            end
        end
    endtask

    task automatic test_load_in_reset();
        logic [2:0] exp3;
        int c;
        do_reset();
        bus.i_div = 16'd3;
        bus.i_div_load = 1'b1;
        tick();
        bus.i_div_load = 1'b0;
        n_cmp++;
        if ({bus.o_pend, bus.o_div} !== {1'b1, 16'd8}) begin
            n_bad++;
            $display("FAIL n3_pending: got pend %b div %0d expected pend 1 div 8", bus.o_pend, bus.o_div);
        end
        tick();
        n_cmp++;
        if ({bus.o_pend, bus.o_div} !== {1'b0, 16'd3}) begin
            n_bad++;
            $display("FAIL n3_applied: got pend %b div %0d expected pend 0 div 3", bus.o_pend, bus.o_div);
        end
        bus.i_ce = 1'b1;
        tick();
        for (int k = 1; k <= 9; k++) begin
            tick();
            c = k % 3;
            exp3 = {c >= 1, c == 1, c == 0};
            n_cmp++;
            if ({bus.o_clk, bus.o_rise_stb, bus.o_fall_stb} !== exp3) begin
                n_bad++;
                $display("FAIL wave_n3 cyc %0d: got %b expected %b",
                         k, {bus.o_clk, bus.o_rise_stb, bus.o_fall_stb}, exp3);
            end
        end
    endtask

    task automatic test_runtime_change();
        logic [2:0] exp3;
        int c;
        do_reset();
        bus.i_div = 16'd4;
        bus.i_div_load = 1'b1;
        tick();
        bus.i_div_load = 1'b0;
        tick();
        bus.i_ce = 1'b1;
        tick();
        tick();
        bus.i_div = 16'd6;
        bus.i_div_load = 1'b1;
        tick();
        bus.i_div_load = 1'b0;
        n_cmp++;
        if ({bus.o_clk, bus.o_rise_stb, bus.o_fall_stb, bus.o_pend, bus.o_div} !== {3'b110, 1'b1, 16'd4}) begin
            n_bad++;
            $display("FAIL chg_pending: got %b pend %b div %0d expected 110 pend 1 div 4",
                     {bus.o_clk, bus.o_rise_stb, bus.o_fall_stb}, bus.o_pend, bus.o_div);
        end
        tick();
        tick();
        n_cmp++;
        if ({bus.o_clk, bus.o_rise_stb, bus.o_fall_stb, bus.o_pend, bus.o_div} !== {3'b001, 1'b0, 16'd6}) begin
            n_bad++;
            $display("FAIL chg_wrap: got %b pend %b div %0d expected 001 pend 0 div 6",
                     {bus.o_clk, bus.o_rise_stb, bus.o_fall_stb}, bus.o_pend, bus.o_div);
        end
        for (int j = 1; j <= 12; j++) begin
            tick();
            c = j % 6;
            exp3 = {c >= 3, c == 3, c == 0};
            n_cmp++;
            if ({bus.o_clk, bus.o_rise_stb, bus.o_fall_stb} !== exp3) begin
                n_bad++;
                $display("FAIL wave_n6 cyc %0d: got %b expected %b",
                         j, {bus.o_clk, bus.o_rise_stb, bus.o_fall_stb}, exp3);
            end
        end
    endtask

    task automatic test_enable_freeze();
        logic [2:0] exp3;
        int c;
        do_reset();
        bus.i_ce = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) tick();
        bus.i_ce = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) bus.i_ce = 1'b1;
            tick();
            n_cmp++;
            if ({bus.o_clk, bus.o_rise_stb, bus.o_fall_stb} !== 3'b100) begin
                n_bad++;
                $display("FAIL frozen cyc %0d: got %b expected 100",
                         k, {bus.o_clk, bus.o_rise_stb, bus.o_fall_stb});
            end
        end
        for (int j = 1; j <= 8; j++) begin
            tick();
            c = (5 + j) % 8;
            exp3 = {c >= 4, c == 4, c == 0};
            n_cmp++;
            if ({bus.o_clk, bus.o_rise_stb, bus.o_fall_stb} !== exp3) begin
                n_bad++;
                $display("FAIL resume cyc %0d: got %b expected %b",
                         j, {bus.o_clk, bus.o_rise_stb, bus.o_fall_stb}, exp3);
            end
        end
    endtask

    // Continues from the end of test_enable_freeze (N=8, count at 5).
    task automatic test_bad_load();
        logic [2:0] exp3;
        int c;
        for (int j = 1; j <= 10; j++) begin
            bus.i_div_load = (j <= 2);
            bus.i_div = (j == 1) ? 16'd1 : 16'd0;
            tick();
            bus.i_div_load = 1'b0;
            c = (5 + j) % 8;
            exp3 = {c >= 4, c == 4, c == 0};
            n_cmp++;
            if ({bus.o_clk, bus.o_rise_stb, bus.o_fall_stb} !== exp3 ||
                {bus.o_err, bus.o_pend, bus.o_div} !== {(j <= 2), 1'b0, 16'd8}) begin
                n_bad++;
                $display("FAIL bad_load cyc %0d: got wave %b err %b pend %b div %0d expected wave %b err %b pend 0 div 8",
                         j, {bus.o_clk, bus.o_rise_stb, bus.o_fall_stb}, bus.o_err, bus.o_pend, bus.o_div,
                         exp3, (j <= 2));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp3;
        int c;
        do_reset();
        bus.i_div = 16'd5;
        bus.i_div_load = 1'b1;
        tick();
        n_cmp++;
        if ({bus.o_pend, bus.o_div} !== {1'b1, 16'd8}) begin
            n_bad++;
            $display("FAIL b2b_first: got pend %b div %0d expected pend 1 div 8", bus.o_pend, bus.o_div);
        end
        bus.i_div = 16'd7;
        tick();
        bus.i_div_load = 1'b0;
        n_cmp++;
        if ({bus.o_pend, bus.o_div} !== {1'b1, 16'd5}) begin
            n_bad++;
            $display("FAIL b2b_overlap: got pend %b div %0d expected pend 1 div 5", bus.o_pend, bus.o_div);
        end
        tick();
        n_cmp++;
        if ({bus.o_pend, bus.o_div} !== {1'b0, 16'd7}) begin
            n_bad++;
            $display("FAIL b2b_final: got pend %b div %0d expected pend 0 div 7", bus.o_pend, bus.o_div);
        end
        bus.i_ce = 1'b1;
        tick();
        for (int k = 1; k <= 14; k++) begin
            tick();
            c = k % 7;
            exp3 = {c >= 3, c == 3, c == 0};
            n_cmp++;
            if ({bus.o_clk, bus.o_rise_stb, bus.o_fall_stb} !== exp3) begin
                n_bad++;
                $display("FAIL wave_n7 cyc %0d: got %b expected %b",
                         k, {bus.o_clk, bus.o_rise_stb, bus.o_fall_stb}, exp3);
            end
        end
    endtask

    task automatic test_reset_pending();
        logic [2:0] exp3;
        int c;
        do_reset();
        bus.i_ce = 1'b1;
        tick();
        bus.i_div = 16'd10;
        bus.i_div_load = 1'b1;
        tick();
        bus.i_div_load = 1'b0;
        tick();
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        n_cmp++;
        if ({bus.o_clk, bus.o_rise_stb, bus.o_fall_stb, bus.o_pend, bus.o_err, bus.o_div} !== {5'b0, 16'd8}) begin
            n_bad++;
            $display("FAIL rst_pending: got %b div %0d expected 00000 div 8",
                     {bus.o_clk, bus.o_rise_stb, bus.o_fall_stb, bus.o_pend, bus.o_err}, bus.o_div);
        end
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            c = k % 8;
            exp3 = {c >= 4, c == 4, c == 0};
            n_cmp++;
            if ({bus.o_clk, bus.o_rise_stb, bus.o_fall_stb} !== exp3 || {bus.o_pend, bus.o_div} !== {1'b0, 16'd8}) begin
                n_bad++;
                $display("FAIL post_rst cyc %0d: got %b pend %b div %0d expected %b pend 0 div 8",
                         k, {bus.o_clk, bus.o_rise_stb, bus.o_fall_stb}, bus.o_pend, bus.o_div, exp3);
            end
        end
    endtask

    initial begin
        bus.i_ce = 1'b0;
        bus.i_div = '0;
        bus.i_div_load = 1'b0;
        test_reset();
        test_default_run();
        test_load_in_reset();
        test_runtime_change();
        test_enable_freeze();
        test_bad_load();
        test_back_to_back();
        test_reset_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/prog_clk_div.md
Name: prog_clk_div

Overview:
- Runtime-programmable integer clock divider with an enable input. It is the successor to the fixed half-period stretcher.
- The output period is N input clocks, where N is loaded at runtime. Odd N is supported.
- Registered edge strobes mark each output edge. A new divisor takes effect only at a period boundary, so the output never glitches.
- Sits between the system clock domain and slow peripherals (SPI/I2C bit clocks, sample-rate ticks). Everything is posedge i_clk; the block does not drive o_clk as a real clock net.

Parameters:
- DIV_WID, 16: width of divisor and internal counter.
- DEFAULT_DIV, 8: divisor active after reset; must satisfy 2 <= DEFAULT_DIV < 2**DIV_WID.

Ports:
- i_clk  in  1  system clock
- i_rstn  in  1  reset, synchronous, active-low
- i_ce  in  1  component enable; 0 freezes divider state
- i_div  in  DIV_WID  requested divisor N
- i_div_load  in  1  one-cycle request to load i_div
- o_clk  out  1  divided clock (registered)
- o_rise_stb  out  1  1-cycle pulse, coincident with o_clk 0->1
- o_fall_stb  out  1  1-cycle pulse, coincident with o_clk 1->0
- o_div  out  DIV_WID  divisor currently in effect
- o_pend  out  1  a legal divisor is waiting for the next period boundary
- o_err  out  1  1-cycle pulse: rejected load (i_div < 2)

Behaviour:

Reset (i_rstn=0 at posedge):
- cnt=0, o_clk=0, both strobes 0, o_err=0.
- o_div=DEFAULT_DIV, o_pend=0, pending register cleared.
- State = RESET.
- Reset has priority over every other event. Reset mid-period or with a load pending discards the pending divisor.

Derived values for the active divisor N:
- L = floor(N/2).
- Low phase = L cycles; high phase = N-L cycles (high is longer for odd N).

State machine:
- RESET -> RUN when i_ce=1.
- RUN -> IDLE when i_ce=0.
- IDLE -> RUN when i_ce=1.
- RESET and IDLE hold cnt, o_clk and o_div; strobes are 0 in both.

RUN, each posedge, next state = RUN:
- cnt_next = (cnt == N-1) ? 0 : cnt+1.
- o_clk <= (cnt_next >= L).
- o_rise_stb <= (cnt_next == L).
- o_fall_stb <= (cnt_next == 0).
- First rising edge after reset occurs L enabled cycles after leaving RESET.

Divisor load:
- i_div_load=1 with i_div >= 2: i_div is captured into pending and o_pend <= 1, in any state including IDLE.
- A newer load overwrites an unapplied pending value.
- i_div_load=1 with i_div < 2: ignored. o_err <= 1 for one cycle; pending and o_pend are unchanged.

Divisor apply:
- In RUN, on the cycle cnt_next == 0 (wrap): if pending is valid, N <= pending, o_div updates, o_pend <= 0. That cycle's o_clk/strobes use cnt_next=0 (low, fall strobe).
- In RESET state or IDLE with cnt == 0: pending is applied on the next posedge.
- Load and apply on the same cycle: the old pending value is applied; the new value becomes pending.

Other rules:
- Enable freeze: while i_ce=0, cnt, o_clk and N are stable. Only pending/o_pend/o_err may change.
- Counter compare uses the full DIV_WID. N = 2**DIV_WID-1 is legal; the counter never overflows.

Test Plan:
1. Reset, i_ce=1, DEFAULT_DIV=8 -> o_clk 0 for 4 cycles, 1 for 4, repeating. o_rise_stb on cycles 4,12,20; o_fall_stb on 8,16; o_div=8.
2. Load N=3 while in RESET, then i_ce=1 -> o_div=3; o_clk pattern low 1 / high 2; rise strobe every 3 cycles.
3. Running N=4, load N=6 at cnt=1 -> o_pend=1; current period completes with 4 cycles; o_div=6 and o_pend=0 from the wrap cycle; next periods are 3 low / 3 high.
4. Running N=8, drop i_ce for 5 cycles at cnt=5 -> o_clk, cnt and strobes frozen (strobes 0); resume continues at cnt=6 with no extra edge.
5. i_div_load with i_div=1, then i_div=0 -> o_err pulses twice; o_div and o_pend unchanged; output period unaffected.
6. Load N=10 (pending), pull i_rstn=0 for 1 cycle at cnt=3 -> o_clk=0, cnt=0, o_pend=0, o_div=DEFAULT_DIV.
